// File: rtl/fft_pkg.sv
// Shared types and constants for the 32-point radix-2 DIT FFT sequencer.
package fft_pkg;

   localparam int unsigned FFT_LOG2N   = 5;
   localparam int unsigned FFT_TW_W    = FFT_LOG2N - 1;
   localparam int unsigned BITREV_MAX  = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_STALL,
      ST_DRAIN,
      ST_DONE
   } fft_seq_state_t;

   // Reverse the low w bits of x (w <= BITREV_MAX); bits above w return 0.
   function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] x,
                                                    input int unsigned w);
      logic [BITREV_MAX-1:0] r;
      r = '0;
      for (int i = 0; i < int'(BITREV_MAX); i++) begin
         if (i < int'(w)) r[3'(i)] = x[3'(int'(w) - 1 - i)];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_seq_if.sv
// Host load/start and butterfly/RAM address bus of the FFT sequencer.
interface fft_seq_if #(
   parameter int unsigned LOG2N = fft_pkg::FFT_LOG2N
);
   localparam int unsigned TW_W = LOG2N - 1;

   logic             fft_start;
   logic             load_data_write;
   logic [LOG2N-1:0] load_data_addr;
   logic             ld_wr_en;
   logic [LOG2N-1:0] ld_wr_addr;
   logic             rd_en;
   logic [LOG2N-1:0] rd_addr_a;
   logic [LOG2N-1:0] rd_addr_b;
   logic [TW_W-1:0]  tw_idx;
   logic             wr_en;
   logic [LOG2N-1:0] wr_addr_a;
   logic [LOG2N-1:0] wr_addr_b;
   logic [2:0]       stage;
   logic             busy;
   logic             fft_done;

   modport slave (
      input  fft_start, load_data_write, load_data_addr,
      output ld_wr_en, ld_wr_addr, rd_en, rd_addr_a, rd_addr_b, tw_idx,
             wr_en, wr_addr_a, wr_addr_b, stage, busy, fft_done
   );

   modport master (
      output fft_start, load_data_write, load_data_addr,
      input  ld_wr_en, ld_wr_addr, rd_en, rd_addr_a, rd_addr_b, tw_idx,
             wr_en, wr_addr_a, wr_addr_b, stage, busy, fft_done
   );

endinterface

// File: rtl/fft_addr_delay.sv
// LAT-stage register line aligning {valid, addr_a, addr_b} with butterfly write-back.
module fft_addr_delay #(
   parameter int unsigned LAT = 3,
   parameter int unsigned AW  = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [AW-1:0] in_a,
   input  logic [AW-1:0] in_b,
   output logic          out_valid,
   output logic [AW-1:0] out_a,
   output logic [AW-1:0] out_b
);

   localparam int unsigned W = 1 + 2 * AW;

   logic [W-1:0] line [LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(LAT); i++) line[i] <= '0;
      end else begin
         line[0] <= {in_valid, in_a, in_b};
         for (int i = 1; i < int'(LAT); i++) line[i] <= line[i-1];
      end
   end

   assign {out_valid, out_a, out_b} = line[LAT-1];

endmodule

// File: rtl/fft_seq_ctrl.sv
// In-place radix-2 DIT FFT sequencer: host load steering, butterfly addressing, write-back.
// Optional macro FFT_BITREV_LOAD_EN bit-reverses host load addresses.
module fft_seq_ctrl
   import fft_pkg::*;
#(
   parameter int unsigned LOG2N      = FFT_LOG2N,
   parameter int unsigned BF_LATENCY = 3
) (
   input  logic     clk,
   input  logic     rst_n,
   fft_seq_if.slave bus
);

   localparam int unsigned K_W    = LOG2N - 1;
   localparam int unsigned TW_W   = LOG2N - 1;
   localparam int unsigned ST_W   = 3;
   localparam int unsigned CNT_W  = 3;
   localparam int unsigned HALF_N = 1 << (LOG2N - 1);

   localparam logic [K_W-1:0]   K_LAST     = K_W'(HALF_N - 1);
   localparam logic [ST_W-1:0]  STAGE_LAST = ST_W'(LOG2N - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(BF_LATENCY - 1);

   fft_seq_state_t    state, state_n;
   logic [K_W-1:0]    k, k_n;
   logic [ST_W-1:0]   stage_q, stage_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic              issue;
   logic [LOG2N-1:0]  kx, half, pos, addr_a_n, addr_b_n;
   logic [TW_W-1:0]   tw_n;
   logic              ld_en_n;
   logic [LOG2N-1:0]  ld_addr_map;

   logic              rd_en_q;
   logic [LOG2N-1:0]  rd_a_q, rd_b_q;

`ifdef FFT_BITREV_LOAD_EN
   assign ld_addr_map = LOG2N'(bitrev(8'(bus.load_data_addr), LOG2N));
`else
   assign ld_addr_map = bus.load_data_addr;
`endif

   // Next-state, counters and the butterfly to issue in the following cycle.
   always_comb begin
      state_n  = state;
      k_n      = k;
      stage_n  = stage_q;
      cnt_n    = cnt;
      issue    = 1'b0;
      ld_en_n  = 1'b0;
      kx       = '0;
      half     = '0;
      pos      = '0;
      addr_a_n = '0;
      addr_b_n = '0;
      tw_n     = '0;

      unique case (state)
         ST_IDLE: begin
            ld_en_n = bus.load_data_write;
            if (bus.fft_start) begin
               state_n = ST_RUN;
               k_n     = '0;
               stage_n = '0;
               issue   = 1'b1;
            end
         end
         ST_RUN: begin
            if (k == K_LAST) begin
               cnt_n   = '0;
               state_n = (stage_q == STAGE_LAST) ? ST_DRAIN : ST_STALL;
            end else begin
               k_n   = k + K_W'(1);
               issue = 1'b1;
            end
         end
         ST_STALL: begin
            if (cnt == GAP_LAST) begin
               state_n = ST_RUN;
               stage_n = stage_q + ST_W'(1);
               k_n     = '0;
               issue   = 1'b1;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         ST_DRAIN: begin
            if (cnt == GAP_LAST) state_n = ST_DONE;
            else                 cnt_n   = cnt + CNT_W'(1);
         end
         ST_DONE: begin
            state_n = ST_IDLE;
            stage_n = '0;
         end
         default: state_n = ST_IDLE;
      endcase

      // Butterfly k of a stage pairs a and a+half inside block k>>stage.
      if (issue) begin
         kx       = LOG2N'(k_n);
         half     = LOG2N'(1) << stage_n;
         pos      = kx & (half - LOG2N'(1));
         addr_a_n = ((kx >> stage_n) << (stage_n + ST_W'(1))) | pos;
         addr_b_n = addr_a_n + half;
         tw_n     = TW_W'(pos << (ST_W'(LOG2N - 1) - stage_n));
      end
   end

   // State, counters and every registered output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         k              <= '0;
         stage_q        <= '0;
         cnt            <= '0;
         rd_en_q        <= 1'b0;
         rd_a_q         <= '0;
         rd_b_q         <= '0;
         bus.tw_idx     <= '0;
         bus.stage      <= '0;
         bus.busy       <= 1'b0;
         bus.fft_done   <= 1'b0;
         bus.ld_wr_en   <= 1'b0;
         bus.ld_wr_addr <= '0;
      end else begin
         state          <= state_n;
         k              <= k_n;
         stage_q        <= stage_n;
         cnt            <= cnt_n;
         rd_en_q        <= issue;
         rd_a_q         <= addr_a_n;
         rd_b_q         <= addr_b_n;
         bus.tw_idx     <= tw_n;
         bus.stage      <= stage_n;
         bus.busy       <= (state_n != ST_IDLE);
         bus.fft_done   <= (state_n == ST_DONE);
         bus.ld_wr_en   <= ld_en_n;
         bus.ld_wr_addr <= ld_en_n ? ld_addr_map : '0;
      end
   end

   assign bus.rd_en     = rd_en_q;
   assign bus.rd_addr_a = rd_a_q;
   assign bus.rd_addr_b = rd_b_q;

   fft_addr_delay #(
      .LAT (BF_LATENCY),
      .AW  (LOG2N)
   ) u_wb_delay (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (rd_en_q),
      .in_a      (rd_a_q),
      .in_b      (rd_b_q),
      .out_valid (bus.wr_en),
      .out_a     (bus.wr_addr_a),
      .out_b     (bus.wr_addr_b)
   );

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Self-checking bench for fft_seq_ctrl against a butterfly-schedule reference model.
module tb_fft_seq_ctrl;

   localparam int LOG2N  = 5;
   localparam int N      = 32;
   localparam int LAT    = 3;
   localparam int DONE_C = 81 + 5 * LAT;

   typedef struct {
      int cyc;
      int a;
      int b;
      int tw;
      int st;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   fft_seq_if #(.LOG2N(LOG2N)) bus ();

   fft_seq_ctrl #(.LOG2N(LOG2N), .BF_LATENCY(LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      #200000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   function automatic logic [36:0] all_outs();
      return {bus.ld_wr_en, bus.ld_wr_addr, bus.rd_en, bus.rd_addr_a, bus.rd_addr_b,
              bus.tw_idx, bus.wr_en, bus.wr_addr_a, bus.wr_addr_b, bus.stage,
              bus.busy, bus.fft_done};
   endfunction

   function automatic int exp_ld_addr(input int a);
`ifdef FFT_BITREV_LOAD_EN
      int r = 0;
      for (int i = 0; i < LOG2N; i++)
         if (((a >> i) & 1) == 1) r = r | (1 << (LOG2N - 1 - i));
      return r;
`else
      return a;
`endif
   endfunction

   // Textbook DIT schedule: per stage, blocks of 2*half, twiddle step N/(2*half).
   task automatic build_model(output ev_t rq[$], output ev_t wq[$]);
      ev_t e;
      rq = {};
      wq = {};
      for (int s = 0; s < LOG2N; s++) begin
         int half = 1 << s;
         int groups = (N / 2) / half;
         for (int g = 0; g < groups; g++)
            for (int j = 0; j < half; j++) begin
               e.cyc = 1 + s * (N / 2 + LAT) + g * half + j;
               e.a   = g * 2 * half + j;
               e.b   = e.a + half;
               e.tw  = j * groups;
               e.st  = s;
               rq.push_back(e);
               e.cyc = e.cyc + LAT;
               wq.push_back(e);
            end
      end
   endtask

   task automatic test_reset();
      bus.fft_start = 1'b0;
      bus.load_data_write = 1'b0;
      bus.load_data_addr = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (all_outs() !== 37'd0) begin
         errors++;
         $display("FAIL reset_outputs got=%h want=0", all_outs());
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy got=%b want=0", bus.busy);
      end
   endtask

   task automatic test_load();
      logic [4:0] a;
      for (int i = 0; i < 9; i++) begin
         a = (i == 0) ? 5'd3 : 5'($urandom);
         @(negedge clk);
         bus.load_data_write = 1'b1;
         bus.load_data_addr = a;
         @(negedge clk);
         bus.load_data_write = 1'b0;
         checks++;
         if (bus.ld_wr_en !== 1'b1 || int'(bus.ld_wr_addr) != exp_ld_addr(int'(a))) begin
            errors++;
            $display("FAIL load_addr in=%0h got en=%b addr=%0h want en=1 addr=%0h",
                     a, bus.ld_wr_en, bus.ld_wr_addr, exp_ld_addr(int'(a)));
         end
      end
      @(negedge clk);
      checks++;
      if (bus.ld_wr_en !== 1'b0) begin
         errors++;
         $display("FAIL load_idle_en got=%b want=0", bus.ld_wr_en);
      end
   endtask

   // One full transform; toggle drives random start/load noise while busy.
   task automatic run_transform(input bit toggle, input bit chain_in, input bit chain_out);
      ev_t rq[$], wq[$], e;
      int dones = 0;
      int last_c;
      bit start_ld = 1'b0;
      logic [4:0] ld_a = '0;
      int first_rd[LOG2N];
      int last_wr[LOG2N];
      for (int s = 0; s < LOG2N; s++) begin
         first_rd[s] = 1 << 20;
         last_wr[s] = -1;
      end
      build_model(rq, wq);
      if (!chain_in) begin
         @(negedge clk);
         ld_a = 5'($urandom);
         start_ld = 1'b1;
         bus.fft_start = 1'b1;
         bus.load_data_write = 1'b1;
         bus.load_data_addr = ld_a;
      end
      @(negedge clk);
      bus.fft_start = 1'b0;
      bus.load_data_write = 1'b0;
      last_c = chain_out ? DONE_C + 1 : DONE_C + 4;
      for (int c = 1; c <= last_c; c++) begin
         checks++;
         if (bus.ld_wr_en !== (c == 1 && start_ld)) begin
            errors++;
            $display("FAIL run_ld_en c=%0d got=%b want=%b", c, bus.ld_wr_en, (c == 1 && start_ld));
         end else if (c == 1 && start_ld) begin
            checks++;
            if (int'(bus.ld_wr_addr) != exp_ld_addr(int'(ld_a))) begin
               errors++;
               $display("FAIL start_load_addr got=%0h want=%0h", bus.ld_wr_addr, exp_ld_addr(int'(ld_a)));
            end
         end
         checks++;
         if (bus.busy !== (c <= DONE_C)) begin
            errors++;
            $display("FAIL run_busy c=%0d got=%b want=%b", c, bus.busy, (c <= DONE_C));
         end
         checks++;
         if (bus.fft_done !== (c == DONE_C)) begin
            errors++;
            $display("FAIL run_done c=%0d got=%b want=%b", c, bus.fft_done, (c == DONE_C));
         end
         if (bus.fft_done === 1'b1) dones++;
         if (bus.rd_en === 1'b1) begin
            checks++;
            if (rq.size() == 0) begin
               errors++;
               $display("FAIL rd_extra c=%0d got=1 want=0", c);
            end else begin
               e = rq.pop_front();
               if (c < first_rd[e.st]) first_rd[e.st] = c;
               if (c != e.cyc || int'(bus.rd_addr_a) != e.a || int'(bus.rd_addr_b) != e.b ||
                   int'(bus.tw_idx) != e.tw || int'(bus.stage) != e.st) begin
                  errors++;
                  $display("FAIL rd_issue got c=%0d a=%0d b=%0d tw=%0d st=%0d want c=%0d a=%0d b=%0d tw=%0d st=%0d",
                           c, bus.rd_addr_a, bus.rd_addr_b, bus.tw_idx, bus.stage,
                           e.cyc, e.a, e.b, e.tw, e.st);
               end
            end
         end
         if (bus.wr_en === 1'b1) begin
            checks++;
            if (wq.size() == 0) begin
               errors++;
               $display("FAIL wr_extra c=%0d got=1 want=0", c);
            end else begin
               e = wq.pop_front();
               if (c > last_wr[e.st]) last_wr[e.st] = c;
               if (c != e.cyc || int'(bus.wr_addr_a) != e.a || int'(bus.wr_addr_b) != e.b) begin
                  errors++;
                  $display("FAIL wr_back got c=%0d a=%0d b=%0d want c=%0d a=%0d b=%0d",
                           c, bus.wr_addr_a, bus.wr_addr_b, e.cyc, e.a, e.b);
               end
            end
         end
         if (toggle && c <= DONE_C - 6) begin
            bus.fft_start = 1'($urandom);
            bus.load_data_write = 1'($urandom);
            bus.load_data_addr = 5'($urandom);
         end else begin
            bus.fft_start = 1'b0;
            bus.load_data_write = 1'b0;
         end
         if (chain_out && c == last_c) bus.fft_start = 1'b1;
         else if (c < last_c) @(negedge clk);
      end
      checks++;
      if (rq.size() != 0 || wq.size() != 0) begin
         errors++;
         $display("FAIL missing_events got rd_left=%0d wr_left=%0d want 0/0", rq.size(), wq.size());
      end
      checks++;
      if (dones != 1) begin
         errors++;
         $display("FAIL done_count got=%0d want=1", dones);
      end
      for (int s = 0; s < LOG2N - 1; s++) begin
         checks++;
         if (first_rd[s+1] <= last_wr[s]) begin
            errors++;
            $display("FAIL stage_hazard s=%0d got first_rd=%0d last_wr=%0d want first_rd>last_wr",
                     s, first_rd[s+1], last_wr[s]);
         end
      end
   endtask

   task automatic test_full_run();
      run_transform(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_ignore_during_run();
      run_transform(1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_transform(1'b0, 1'b0, 1'b1);
      run_transform(1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_reset_midrun();
      bit found = 1'b0;
      @(negedge clk);
      bus.fft_start = 1'b1;
      @(negedge clk);
      bus.fft_start = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         if (bus.rd_en === 1'b1 && bus.stage === 3'd2) found = 1'b1;
         else @(negedge clk);
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL midrun_reach_stage2 got=0 want=1");
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (all_outs() !== 37'd0) begin
         errors++;
         $display("FAIL midrun_reset_outputs got=%h want=0", all_outs());
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         checks++;
         if (bus.fft_done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL aborted_run_done c=%0d got done=%b busy=%b want 0/0", c, bus.fft_done, bus.busy);
         end
      end
      run_transform(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_load();
      test_full_run();
      test_ignore_during_run();
      test_back_to_back();
      test_reset_midrun();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
